alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_seq_pkg.sv | 46 ++++
 rtl/alu_sequencer_if.sv | 33 +++
 rtl/alu_sequencer_alu.sv | 27 ++
 rtl/alu_sequencer.sv | 121 ++++++++++++
 tb/tb_alu_sequencer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, ALU control codes and FSM states
// for the multi-cycle ALU sequencer.
package alu_seq_pkg;

  localparam int W = 32;

  typedef enum logic [2:0] {
    OP_NOT = 3'd0,
    OP_AND = 3'd1,
    OP_SHR = 3'd2,
    OP_XOR = 3'd3,
    OP_ADD = 3'd4,
    OP_SUB = 3'd5,
    OP_MUL = 3'd6,
    OP_ILL = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ALU_NOT = 3'b000,
    ALU_AND = 3'b001,
    ALU_SHR = 3'b010,
    ALU_XOR = 3'b011,
    ALU_ADD = 3'b100,
    ALU_SUB = 3'b101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_RESP
  } state_e;

  // Codes 110/111 never reach the ALU; they fold onto ADD.
  function automatic alu_ctrl_e op2ctrl(logic [2:0] op);
    case (op)
      OP_NOT:  return ALU_NOT;
      OP_AND:  return ALU_AND;
      OP_SHR:  return ALU_SHR;
      OP_XOR:  return ALU_XOR;
      OP_SUB:  return ALU_SUB;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/response handshake bundle between
// a requester (master) and the sequencer (slave).
interface alu_sequencer_if;
  import alu_seq_pkg::*;

  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_op;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_carry;
  logic         rsp_zero;
  logic         rsp_neg;
  logic         rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_data,
    input  rsp_carry, rsp_zero, rsp_neg, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_data,
    output rsp_carry, rsp_zero, rsp_neg, rsp_err
  );

endinterface

// File: rtl/alu_sequencer_alu.sv
// Combinational 32-bit ALU; cout is bit 32
// of the add/sub result.
module alu
  import alu_seq_pkg::*;
(
  input  alu_ctrl_e    ctrl,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] dout,
  output logic         cout
);

  always_comb begin
    dout = '0;
    cout = 1'b0;
    case (ctrl)
      ALU_NOT: dout = ~a;
      ALU_AND: dout = a & b;
      ALU_SHR: dout = a >> b;
      ALU_XOR: dout = a ^ b;
      ALU_ADD: {cout, dout} = {1'b0, a} + {1'b0, b};
      ALU_SUB: {cout, dout} = {1'b0, a} - {1'b0, b};
      default: dout = '0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Sequencer: one ALU op per request, shift-add
// multiply over 32 cycles, held response.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  alu_sequencer_if.slave   bus
);

  state_e       state, state_nx;
  logic [2:0]   op_q;
  logic [W-1:0] a_q, b_q, acc_q, data_q;
  logic [4:0]   cnt_q;
  logic         carry_q, zero_q, neg_q, err_q;

  alu_ctrl_e    ctrl;
  logic [W-1:0] alu_a, alu_b, alu_dout;
  logic         alu_cout;
  logic [W-1:0] res;
  logic         load_res;
  logic         mul_last;

  // MUL reuses the ADD path: acc + multiplicand.
  always_comb begin
    ctrl  = ALU_ADD;
    alu_a = acc_q;
    alu_b = a_q;
    if (state == S_EXEC) begin
      ctrl  = op2ctrl(op_q);
      alu_a = a_q;
      alu_b = b_q;
    end
  end

  alu u_alu (
    .ctrl (ctrl),
    .a    (alu_a),
    .b    (alu_b),
    .dout (alu_dout),
    .cout (alu_cout)
  );

  assign mul_last = (state == S_MUL) && (cnt_q == 5'd31);
  assign load_res = (state == S_EXEC) || mul_last;
  assign res = (state == S_MUL && !b_q[0]) ? acc_q : alu_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:
        if (bus.req_valid) begin
          if (bus.req_op == OP_ILL)      state_nx = S_RESP;
          else if (bus.req_op == OP_MUL) state_nx = S_MUL;
          else                           state_nx = S_EXEC;
        end
      S_EXEC: state_nx = S_RESP;
      S_MUL:  if (mul_last) state_nx = S_RESP;
      S_RESP: if (bus.rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (state == S_IDLE && bus.req_valid) begin
        op_q  <= bus.req_op;
        a_q   <= bus.req_a;
        b_q   <= bus.req_b;
        acc_q <= '0;
        cnt_q <= '0;
        if (bus.req_op == OP_ILL) begin
          data_q  <= '0;
          carry_q <= 1'b0;
          zero_q  <= 1'b0;
          neg_q   <= 1'b0;
          err_q   <= 1'b1;
        end
      end
      if (state == S_MUL) begin
        if (b_q[0]) acc_q <= alu_dout;
        a_q   <= a_q << 1;
        b_q   <= b_q >> 1;
        cnt_q <= cnt_q + 5'd1;
      end
      if (load_res) begin
        data_q  <= res;
        zero_q  <= (res == '0);
        neg_q   <= res[W-1];
        err_q   <= 1'b0;
        carry_q <= (state == S_EXEC) && alu_cout &&
                   (op_q == OP_ADD || op_q == OP_SUB);
      end
    end
  end

  assign bus.req_ready = (state == S_IDLE);
  assign bus.rsp_valid = (state == S_RESP);
  assign bus.rsp_data  = data_q;
  assign bus.rsp_carry = carry_q;
  assign bus.rsp_zero  = zero_q;
  assign bus.rsp_neg   = neg_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Table-driven scoreboard bench for alu_sequencer
// with backpressure and mid-multiply reset sequences.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_sequencer_if bus();

  alu_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data;
    logic        carry;
    logic        err;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        carry;
    logic        zero;
    logic        neg;
    logic        err;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[13];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic c,
                      input logic e, input int lat,
                      input string name);
    exp_t x;
    x.data  = d;
    x.carry = c;
    x.err   = e;
    x.zero  = !e && (d == 32'd0);
    x.neg   = !e && d[31];
    x.lat   = lat;
    x.name  = name;
    sb.push_back(x);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit track,
                       input logic [31:0] d, input logic c,
                       input logic e, input int lat,
                       input string name);
    int n = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      chk({name, " accept timeout"}, 32'd0, 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    if (track) push(d, c, e, lat, name);
    @(posedge clk);
    #1;
    // Scramble inputs after accept; the op in flight must not care.
    bus.req_valid = 1'b0;
    bus.req_op    = 3'($urandom);
    bus.req_a     = ~a;
    bus.req_b     = $urandom;
  endtask

  task automatic collect();
    exp_t x;
    int lat = 1;
    @(negedge clk);
    while (!bus.rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (sb.size() == 0) begin
      chk("scoreboard empty", 32'd0, 32'd1);
      return;
    end
    x = sb.pop_front();
    if (!bus.rsp_valid) begin
      chk({x.name, " rsp timeout"}, 32'd0, 32'd1);
      return;
    end
    chk({x.name, " latency"}, 32'(lat), 32'(x.lat));
    chk({x.name, " data"},  bus.rsp_data,  x.data);
    chk({x.name, " carry"}, bus.rsp_carry, x.carry);
    chk({x.name, " zero"},  bus.rsp_zero,  x.zero);
    chk({x.name, " neg"},   bus.rsp_neg,   x.neg);
    chk({x.name, " err"},   bus.rsp_err,   x.err);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_a     = 32'd0;
    bus.req_b     = 32'd0;
    bus.rsp_ready = 1'b1;

    tbl[0]  = '{OP_NOT, 32'h0F0F0F0F, 32'h0,        32'hF0F0F0F0, 1'b0, 1'b0, 2};
    tbl[1]  = '{OP_AND, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b0, 1'b0, 2};
    tbl[2]  = '{OP_SHR, 32'h80000000, 32'd4,        32'h08000000, 1'b0, 1'b0, 2};
    tbl[3]  = '{OP_XOR, 32'h12345678, 32'h12345678, 32'h00000000, 1'b0, 1'b0, 2};
    tbl[4]  = '{OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 2};
    tbl[5]  = '{OP_SUB, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b1, 1'b0, 2};
    tbl[6]  = '{OP_SUB, 32'd7,        32'd5,        32'h00000002, 1'b0, 1'b0, 2};
    tbl[7]  = '{OP_MUL, 32'h00010001, 32'h00000003, 32'h00030003, 1'b0, 1'b0, 33};
    tbl[8]  = '{OP_MUL, 32'h80000000, 32'd2,        32'h00000000, 1'b0, 1'b0, 33};
    tbl[9]  = '{OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 33};
    tbl[10] = '{OP_ILL, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b1, 1};
    tbl[11] = '{OP_ADD, 32'd1,        32'd2,        32'h00000003, 1'b0, 1'b0, 2};
    tbl[12] = '{OP_AND, 32'hFFFFFFFF, 32'h80000001, 32'h80000001, 1'b0, 1'b0, 2};

    repeat (2) @(negedge clk);
    chk("rst rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst rsp_data",  bus.rsp_data,  32'd0);
    chk("rst rsp_zero",  bus.rsp_zero,  1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst req_ready", bus.req_ready, 1'b1);
    chk("post-rst rsp_valid", bus.rsp_valid, 1'b0);
    chk("post-rst flags",
        {bus.rsp_carry, bus.rsp_zero, bus.rsp_neg, bus.rsp_err}, 4'd0);

    for (int i = 0; i < 13; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, 1'b1, tbl[i].data,
            tbl[i].carry, tbl[i].err, tbl[i].lat,
            $sformatf("vec%0d", i));
      collect();
    end

    // Backpressure: first result held while a second op waits.
    bus.rsp_ready = 1'b0;
    issue(OP_ADD, 32'd10, 32'd20, 1'b1, 32'd30, 1'b0, 1'b0, 2,
          "bp first");
    collect();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = OP_SUB;
    bus.req_a     = 32'd100;
    bus.req_b     = 32'd1;
    for (int i = 0; i < 10; i++) begin
      chk("bp data stable", bus.rsp_data, 32'd30);
      chk("bp req_ready",   bus.req_ready, 1'b0);
      chk("bp rsp_valid",   bus.rsp_valid, 1'b1);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp taken rsp_valid", bus.rsp_valid, 1'b0);
    chk("bp taken req_ready", bus.req_ready, 1'b1);
    push(32'd99, 1'b0, 1'b0, 2, "bp second");
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_a     = 32'hDEADBEEF;
    collect();

    // Reset during multiply iteration 15.
    issue(OP_MUL, 32'd3, 32'd5, 1'b0, 32'd0, 1'b0, 1'b0, 0, "mul rst");
    repeat (15) @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid-mul rst rsp_valid", bus.rsp_valid, 1'b0);
    chk("mid-mul rst rsp_data",  bus.rsp_data,  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid-mul release req_ready", bus.req_ready, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.rsp_valid) seen = 1'b1;
      @(negedge clk);
    end
    chk("no stale response", seen, 1'b0);

    issue(OP_XOR, 32'hA5A5A5A5, 32'h0000FFFF, 1'b1, 32'hA5A55A5A,
          1'b0, 1'b0, 2, "after rst");
    collect();

    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
